// File: rtl/opb_reg_bank_pkg.sv
// opb_reg_bank_pkg: slave FSM states plus OPB<->user bit ordering and byte-merge helpers
package opb_reg_bank_pkg;
   typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;
   function automatic logic [31:0] opb2user(input logic [0:31] d);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[31-i] = d[i];
      return r;
   endfunction
   function automatic logic [0:31] user2opb(input logic [31:0] u);
      logic [0:31] r;
      for (int i = 0; i < 32; i++) r[i] = u[31-i];
      return r;
   endfunction
   function automatic logic [3:0] be2user(input logic [0:3] b);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[3-i] = b[i];
      return r;
   endfunction
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wr, input logic [3:0] be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i+:8] = be[i] ? wr[8*i+:8] : old[8*i+:8];
      return r;
   endfunction
endpackage

// File: rtl/opb_slave_ack_fsm.sv
// opb_slave_ack_fsm: one-cycle transfer acknowledge; WAIT blocks a second ack while select stays high
import opb_reg_bank_pkg::*;
module opb_slave_ack_fsm (
   input  logic   clk,
   input  logic   rst,
   input  logic   hit,
   input  logic   select,
   output logic   ack,
   output state_t state
);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         ack   <= 1'b0;
      end else begin
         ack   <= state == IDLE && hit;
         state <= state == IDLE ? (hit ? ACK : IDLE) : state == ACK ? WAIT : (select ? WAIT : IDLE);
      end
endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// opb_register_bank_ppc2simulink: bank of PPC-writable 32-bit registers on OPB with per-register update strobes
// Optional double-buffered commit mode: define OPB_REG_BANK_SHADOW_EN
import opb_reg_bank_pkg::*;
module opb_register_bank_ppc2simulink #(
   parameter logic [31:0] C_BASEADDR    = 32'hFFFFFFFF,
   parameter logic [31:0] C_HIGHADDR    = 32'h00000000,
   parameter int          C_OPB_AWIDTH  = 32,
   parameter int          C_OPB_DWIDTH  = 32,
   parameter int          C_NUM_REGS    = 4,
   parameter logic [31:0] C_RESET_VALUE = 32'h0,
   parameter string       C_FAMILY      = "virtex5"
) (
   input  logic                      OPB_Clk,
   input  logic                      OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
   input  logic [0:3]                OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
   input  logic                      OPB_RNW,
   input  logic                      OPB_select,
   input  logic                      OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
   output logic                      Sl_xferAck,
   output logic                      Sl_errAck,
   output logic                      Sl_retry,
   output logic                      Sl_toutSup,
   output logic [32*C_NUM_REGS-1:0]  user_data_out,
   output logic [C_NUM_REGS-1:0]     user_data_valid
);
   logic [C_NUM_REGS-1:0][31:0] regs;
   logic [C_NUM_REGS-1:0]       wsel;
   logic [31:0]                 off, wdata, rdata;
   logic [29:0]                 idx;
   logic [3:0]                  be;
   logic                        hit, take, wr;
   state_t                      state;
   logic                        unused;
   assign off   = OPB_ABus - C_BASEADDR;
   assign idx   = off[31:2];
   assign wdata = opb2user(OPB_DBus);
   assign be    = be2user(OPB_BE);
   assign hit   = OPB_select && OPB_ABus >= C_BASEADDR && OPB_ABus <= C_HIGHADDR;
   assign take  = hit && state == IDLE;
   assign wr    = take && !OPB_RNW && |be;
   assign unused = &{1'b0, OPB_seqAddr, off[1:0]};
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;
   assign user_data_out = regs;
   opb_slave_ack_fsm u_fsm (
      .clk    (OPB_Clk),
      .rst    (OPB_Rst),
      .hit    (hit),
      .select (OPB_select),
      .ack    (Sl_xferAck),
      .state  (state)
   );
`ifdef OPB_REG_BANK_SHADOW_EN
   logic [C_NUM_REGS-1:0][31:0] shadow;
   logic [C_NUM_REGS-1:0]       pend;
   logic                        commit;
   assign commit = wr && idx == 30'(C_NUM_REGS) && be[3] && wdata[31];
`endif
   always_comb begin
      wsel  = '0;
      rdata = '0;
      for (int k = 0; k < C_NUM_REGS; k++) begin
         wsel[k] = wr && idx == 30'(k);
         if (idx == 30'(k)) rdata = regs[k];
      end
`ifdef OPB_REG_BANK_SHADOW_EN
      if (idx == 30'(C_NUM_REGS)) rdata = 32'(pend);
`endif
   end
   always_ff @(posedge OPB_Clk or posedge OPB_Rst)
      if (OPB_Rst) begin
         regs            <= {C_NUM_REGS{C_RESET_VALUE}};
         user_data_valid <= '0;
         Sl_DBus         <= '0;
`ifdef OPB_REG_BANK_SHADOW_EN
         shadow          <= {C_NUM_REGS{C_RESET_VALUE}};
         pend            <= '0;
`endif
      end else begin
         Sl_DBus <= take && OPB_RNW ? user2opb(rdata) : '0;
`ifdef OPB_REG_BANK_SHADOW_EN
         for (int k = 0; k < C_NUM_REGS; k++) begin
            if (wsel[k]) shadow[k] <= merge(shadow[k], wdata, be);
            if (commit && pend[k]) regs[k] <= shadow[k];
         end
         pend            <= commit ? '0 : pend | wsel;
         user_data_valid <= commit ? pend : '0;
`else
         for (int k = 0; k < C_NUM_REGS; k++)
            if (wsel[k]) regs[k] <= merge(regs[k], wdata, be);
         user_data_valid <= wsel;
`endif
      end
endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// tb_opb_register_bank_ppc2simulink: directed checks of the OPB register bank (direct or shadow build)
module tb_opb_register_bank_ppc2simulink;
   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam logic [31:0] RV   = 32'h0000_00A5;
   logic         clk = 0, rst = 1;
   logic [0:31]  abus = '0, dbus = '0, sl_dbus;
   logic [0:3]   be_s = '0;
   logic         rnw = 0, sel = 0, seq = 0;
   logic         ack, err, rty, tout;
   logic [127:0] udo;
   logic [3:0]   valid;
   int           pass = 0, total = 0;
   logic         t_ack;
   logic [31:0]  t_db;
   logic [3:0]   t_val;
   logic [127:0] t_out;
   logic [2:0]   t_post;
   logic [127:0] exp_out;
   logic [31:0]  exp0;
   int           acks;
   always #5 clk = ~clk;
   opb_register_bank_ppc2simulink #(
      .C_BASEADDR(BASE), .C_HIGHADDR(BASE + 32'hFF), .C_NUM_REGS(4), .C_RESET_VALUE(RV)
   ) dut (
      .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be_s), .OPB_DBus(dbus),
      .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sl_dbus),
      .Sl_xferAck(ack), .Sl_errAck(err), .Sl_retry(rty), .Sl_toutSup(tout),
      .user_data_out(udo), .user_data_valid(valid)
   );
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      total++;
      assert (obs === expv) pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
   endtask
   task automatic xfer(input logic [31:0] a, input logic r, input logic [0:3] b, input logic [31:0] d);
      @(negedge clk);
      abus = a; rnw = r; be_s = b; dbus = d; sel = 1;
      @(posedge clk); #1;
      t_ack = ack; t_db = sl_dbus; t_val = valid; t_out = udo;
      @(negedge clk);
      sel = 0; rnw = 0; be_s = '0; dbus = '0;
      @(posedge clk); #1;
      t_post = {ack, |valid, |sl_dbus};
      @(posedge clk); #1;
      t_post = t_post | {ack, |valid, |sl_dbus};
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out", udo, {4{RV}});
      chk("reset_valid", 128'(valid), 128'(0));
      chk("reset_dbus", 128'(sl_dbus), 128'(0));
      chk("reset_ack", 128'(ack), 128'(0));
      @(negedge clk) rst = 0;
`ifdef OPB_REG_BANK_SHADOW_EN
      xfer(BASE + 32'h0, 0, 4'b1111, 32'h1111_1111);
      chk("sh_wr0_ack", 128'(t_ack), 128'(1));
      chk("sh_wr0_valid", 128'(t_val), 128'(0));
      chk("sh_wr0_out", t_out, {4{RV}});
      xfer(BASE + 32'hC, 0, 4'b1111, 32'h3333_3333);
      chk("sh_wr3_valid", 128'(t_val), 128'(0));
      chk("sh_wr3_out", t_out, {4{RV}});
      xfer(BASE + 32'h10, 1, 4'b1111, 32'h0);
      chk("sh_pend_rd", 128'(t_db), 128'(32'h9));
      xfer(BASE + 32'h10, 0, 4'b1000, 32'h8000_0000);
      chk("sh_commit_ack", 128'(t_ack), 128'(1));
      chk("sh_commit_valid", 128'(t_val), 128'(4'b1001));
      chk("sh_commit_out", t_out, {32'h3333_3333, RV, RV, 32'h1111_1111});
      chk("sh_commit_post", 128'(t_post), 128'(0));
      xfer(BASE + 32'h10, 1, 4'b1111, 32'h0);
      chk("sh_pend_clear", 128'(t_db), 128'(0));
      xfer(BASE + 32'h10, 0, 4'b1000, 32'h8000_0000);
      chk("sh_empty_commit_ack", 128'(t_ack), 128'(1));
      chk("sh_empty_commit_valid", 128'(t_val), 128'(0));
      exp_out = {32'h3333_3333, RV, RV, 32'h1111_1111};
      exp0 = 32'h1111_1111;
`else
      xfer(BASE + 32'h8, 0, 4'b1111, 32'h1234_5678);
      chk("wr2_ack", 128'(t_ack), 128'(1));
      chk("wr2_valid", 128'(t_val), 128'(4'b0100));
      chk("wr2_out", t_out, {RV, 32'h1234_5678, RV, RV});
      chk("wr2_post", 128'(t_post), 128'(0));
      xfer(BASE + 32'h8, 1, 4'b1111, 32'h0);
      chk("rd2_ack", 128'(t_ack), 128'(1));
      chk("rd2_data", 128'(t_db), 128'(32'h1234_5678));
      chk("rd2_valid", 128'(t_val), 128'(0));
      chk("rd2_post", 128'(t_post), 128'(0));
      xfer(BASE + 32'h8, 0, 4'b0010, 32'h0000_AB00);
      chk("byte1_valid", 128'(t_val), 128'(4'b0100));
      chk("byte1_out", t_out, {RV, 32'h1234_AB78, RV, RV});
      xfer(BASE + 32'h8, 0, 4'b1000, 32'hCD00_0000);
      chk("byte3_out", t_out, {RV, 32'hCD34_AB78, RV, RV});
      xfer(BASE + 32'h4, 0, 4'b0000, 32'hFFFF_FFFF);
      chk("be0_ack", 128'(t_ack), 128'(1));
      chk("be0_valid", 128'(t_val), 128'(0));
      chk("be0_out", t_out, {RV, 32'hCD34_AB78, RV, RV});
      xfer(BASE + 32'h10, 0, 4'b1000, 32'h8000_0000);
      chk("ctrl_wr_valid", 128'(t_val), 128'(0));
      xfer(BASE + 32'h10, 1, 4'b1111, 32'h0);
      chk("ctrl_rd_ack", 128'(t_ack), 128'(1));
      chk("ctrl_rd_data", 128'(t_db), 128'(0));
      exp_out = {RV, 32'hCD34_AB78, RV, RV};
      exp0 = RV;
`endif
      xfer(BASE + 32'h14, 1, 4'b1111, 32'h0);
      chk("unmap_rd_ack", 128'(t_ack), 128'(1));
      chk("unmap_rd_data", 128'(t_db), 128'(0));
      chk("unmap_rd_valid", 128'(t_val), 128'(0));
      xfer(BASE + 32'h18, 0, 4'b1111, 32'hFFFF_FFFF);
      chk("unmap_wr_ack", 128'(t_ack), 128'(1));
      chk("unmap_wr_valid", 128'(t_val), 128'(0));
      chk("unmap_wr_out", t_out, exp_out);
      xfer(BASE + 32'h100, 1, 4'b1111, 32'h0);
      chk("oor_ack", 128'({t_ack, t_post}), 128'(0));
      @(negedge clk);
      abus = BASE; rnw = 1; be_s = 4'b1111; sel = 1;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            acks++;
            chk("held_data", 128'(sl_dbus), 128'(exp0));
         end
      end
      @(negedge clk) sel = 0;
      repeat (2) @(posedge clk);
      chk("held_acks", 128'(acks), 128'(1));
      @(negedge clk);
      abus = BASE + 32'h4; rnw = 0; be_s = 4'b1111; dbus = 32'hDEAD_BEEF; sel = 1;
      @(posedge clk); #1;
      rst = 1;
      #1;
      chk("rst_mid_ack", 128'(ack), 128'(0));
      chk("rst_mid_out", udo, {4{RV}});
      chk("rst_mid_valid", 128'(valid), 128'(0));
      @(negedge clk);
      rst = 0; sel = 0; rnw = 0; be_s = '0; dbus = '0;
      xfer(BASE + 32'h4, 1, 4'b1111, 32'h0);
      chk("post_rst_ack", 128'(t_ack), 128'(1));
      chk("post_rst_data", 128'(t_db), 128'(RV));
      xfer(BASE + 32'h4, 0, 4'b1111, 32'h0BAD_F00D);
      chk("post_rst_wr_ack", 128'(t_ack), 128'(1));
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
